// File: rtl/arc4_ctrl_if.sv
// arc4_ctrl_if: start handshake, key and the three engine S-ports.
// slave = controller side, master = task top / engine side.
// err exists only when ARC4_CTRL_WDOG_EN is defined.
interface arc4_ctrl_if;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [23:0] key_q;

  logic        init_en;
  logic        init_rdy;
  logic [7:0]  init_addr;
  logic [7:0]  init_wrdata;
  logic        init_wren;

  logic        ksa_en;
  logic        ksa_rdy;
  logic [7:0]  ksa_addr;
  logic [7:0]  ksa_wrdata;
  logic        ksa_wren;

  logic        prga_en;
  logic        prga_rdy;
  logic [7:0]  prga_addr;
  logic [7:0]  prga_wrdata;
  logic        prga_wren;

  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;
  logic [1:0]  phase;
`ifdef ARC4_CTRL_WDOG_EN
  logic        err;
`endif

  modport slave (
`ifdef ARC4_CTRL_WDOG_EN
    output err,
`endif
    input  en, key,
    input  init_rdy, init_addr, init_wrdata, init_wren,
    input  ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_rdy, prga_addr, prga_wrdata, prga_wren,
    output rdy, key_q, phase,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
`ifdef ARC4_CTRL_WDOG_EN
    input  err,
`endif
    output en, key,
    output init_rdy, init_addr, init_wrdata, init_wren,
    output ksa_rdy, ksa_addr, ksa_wrdata, ksa_wren,
    output prga_rdy, prga_addr, prga_wrdata, prga_wren,
    input  rdy, key_q, phase,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_ctrl.sv
// arc4_ctrl: runs init -> ksa -> prga via en/rdy and muxes the single
// S-memory port to whichever engine owns the current phase.
// Ports: clk, rst (sync, active-high), bus (arc4_ctrl_if.slave):
//   en/rdy/key/key_q start handshake, <eng>_en/_rdy/_addr/_wrdata/_wren
//   per engine, s_addr/s_wrdata/s_wren memory port, phase, err.
// Param TIMEOUT_CYCLES: per-phase watchdog limit.
// Define ARC4_CTRL_WDOG_EN to build the watchdog, ERR state and err.
module arc4_ctrl #(
  parameter int TIMEOUT_CYCLES = 8192
) (
  input  logic       clk,
  input  logic       rst,
  arc4_ctrl_if.slave bus
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INIT_GO   = 3'd1;
  localparam logic [2:0] ST_INIT_WAIT = 3'd2;
  localparam logic [2:0] ST_KSA_GO    = 3'd3;
  localparam logic [2:0] ST_KSA_WAIT  = 3'd4;
  localparam logic [2:0] ST_PRGA_GO   = 3'd5;
  localparam logic [2:0] ST_PRGA_WAIT = 3'd6;
`ifdef ARC4_CTRL_WDOG_EN
  localparam logic [2:0] ST_ERR       = 3'd7;
`endif

  logic [2:0]  state_q;
  logic [2:0]  state_d;
  logic        first_q;
  logic [23:0] key_q;
  logic [1:0]  phase_q;
  logic [1:0]  phase_d;
  logic        in_init;
  logic        in_ksa;
  logic        in_prga;
  logic        in_wait;
  logic [7:0]  s_addr;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  assign in_init = (state_q == ST_INIT_GO) ||
                   (state_q == ST_INIT_WAIT);
  assign in_ksa  = (state_q == ST_KSA_GO) ||
                   (state_q == ST_KSA_WAIT);
  assign in_prga = (state_q == ST_PRGA_GO) ||
                   (state_q == ST_PRGA_WAIT);
  assign in_wait = (state_q == ST_INIT_WAIT) ||
                   (state_q == ST_KSA_WAIT) ||
                   (state_q == ST_PRGA_WAIT);

`ifdef ARC4_CTRL_WDOG_EN
  localparam logic [15:0] WD_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [15:0] wd_q;
  logic        wd_trip;

  // Trips on the wait cycle that brings the count to the limit.
  assign wd_trip = in_wait &&
                   ((wd_q + 16'd1) >= WD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= 16'd0;
    end else if (state_d != state_q) begin
      wd_q <= 16'd0;
    end else if (in_wait) begin
      wd_q <= wd_q + 16'd1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // first_q marks the guard cycle of a WAIT state: the engine
  // still shows rdy=1 for one cycle after seeing its en.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.en) state_d = ST_INIT_GO;
      ST_INIT_GO:
        if (bus.init_rdy) state_d = ST_INIT_WAIT;
      ST_INIT_WAIT:
        if (!first_q && bus.init_rdy) state_d = ST_KSA_GO;
      ST_KSA_GO:
        if (bus.ksa_rdy) state_d = ST_KSA_WAIT;
      ST_KSA_WAIT:
        if (!first_q && bus.ksa_rdy) state_d = ST_PRGA_GO;
      ST_PRGA_GO:
        if (bus.prga_rdy) state_d = ST_PRGA_WAIT;
      ST_PRGA_WAIT:
        if (!first_q && bus.prga_rdy) state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
`ifdef ARC4_CTRL_WDOG_EN
    if (state_q == ST_ERR) begin
      state_d = ST_ERR;
    end else if (wd_trip && (state_d == state_q)) begin
      state_d = ST_ERR;
    end
`endif
  end

  // phase is registered from the next state so it tracks
  // state_q exactly; ERR keeps whatever phase hung.
  always_comb begin
    phase_d = phase_q;
    unique case (state_d)
      ST_IDLE:                  phase_d = 2'd0;
      ST_INIT_GO, ST_INIT_WAIT: phase_d = 2'd1;
      ST_KSA_GO, ST_KSA_WAIT:   phase_d = 2'd2;
      ST_PRGA_GO, ST_PRGA_WAIT: phase_d = 2'd3;
      default:                  phase_d = phase_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      first_q <= 1'b0;
      key_q   <= 24'd0;
      phase_q <= 2'd0;
    end else begin
      state_q <= state_d;
      first_q <= (state_d != state_q);
      phase_q <= phase_d;
      if ((state_q == ST_IDLE) && bus.en) begin
        key_q <= bus.key;
      end
    end
  end

  always_comb begin
    s_addr   = 8'd0;
    s_wrdata = 8'd0;
    s_wren   = 1'b0;
    unique case (1'b1)
      in_init: begin
        s_addr   = bus.init_addr;
        s_wrdata = bus.init_wrdata;
        s_wren   = bus.init_wren;
      end
      in_ksa: begin
        s_addr   = bus.ksa_addr;
        s_wrdata = bus.ksa_wrdata;
        s_wren   = bus.ksa_wren;
      end
      in_prga: begin
        s_addr   = bus.prga_addr;
        s_wrdata = bus.prga_wrdata;
        s_wren   = bus.prga_wren;
      end
      default: begin
        s_addr   = 8'd0;
        s_wrdata = 8'd0;
        s_wren   = 1'b0;
      end
    endcase
  end

  assign bus.rdy      = (state_q == ST_IDLE);
  assign bus.key_q    = key_q;
  assign bus.phase    = phase_q;
  assign bus.init_en  = (state_q == ST_INIT_GO) && bus.init_rdy;
  assign bus.ksa_en   = (state_q == ST_KSA_GO) && bus.ksa_rdy;
  assign bus.prga_en  = (state_q == ST_PRGA_GO) && bus.prga_rdy;
  assign bus.s_addr   = s_addr;
  assign bus.s_wrdata = s_wrdata;
  assign bus.s_wren   = s_wren;
`ifdef ARC4_CTRL_WDOG_EN
  assign bus.err      = (state_q == ST_ERR);
`endif

endmodule

// File: tb/tb_arc4_ctrl.sv
// tb_arc4_ctrl: stub engines plus a cycle-timeline model of a run.
// Table vectors for arbitration, directed corner cases, random runs.
`timescale 1ns/1ps
module tb_arc4_ctrl;
  localparam int TO = 64;
`ifdef ARC4_CTRL_WDOG_EN
  localparam int LONG = 40;
`else
  localparam int LONG = 300;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arc4_ctrl_if bus();

  arc4_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Stub engines: en seen at edge N -> rdy still 1 in cycle N+1,
  // then rdy=0 for blen cycles, then idle again.
  int   blen[3];
  logic pend[3];
  int   bcnt[3];
  int   blk_until = -1;
  logic [2:0] eng_en;
  assign eng_en = {bus.prga_en, bus.ksa_en, bus.init_en};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        pend[i] <= 1'b0;
        bcnt[i] <= 0;
      end else if (pend[i]) begin
        pend[i] <= 1'b0;
        bcnt[i] <= blen[i];
      end else if (bcnt[i] > 0) begin
        bcnt[i] <= bcnt[i] - 1;
      end else if (eng_en[i] === 1'b1) begin
        pend[i] <= 1'b1;
      end
    end
  end

  assign bus.init_rdy = (bcnt[0] == 0) && (cyc > blk_until);
  assign bus.ksa_rdy  = (bcnt[1] == 0);
  assign bus.prga_rdy = (bcnt[2] == 0);

  // Run model: accept in cycle k; g0 = k+1 leaves IDLE,
  // each phase costs GO wait + en pulse + guard + busy + 1.
  logic        run_on = 1'b0;
  int          g0, c0, c1, c2, cend;
  logic [23:0] key_prev = 24'd0;
  logic [23:0] key_new  = 24'd0;

  function automatic logic model_idle();
    return !run_on || (cyc < g0) || (cyc >= cend);
  endfunction

  function automatic logic [1:0] exp_phase();
    if (model_idle()) return 2'd0;
    if (cyc < c1) return 2'd1;
    if (cyc < c2) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [23:0] exp_key();
    return (run_on && cyc >= g0) ? key_new : key_prev;
  endfunction

  int n_en[3] = '{0, 0, 0};
  int t_en[3] = '{-1, -1, -1};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (eng_en[i] === 1'b1) begin
        n_en[i]++;
        t_en[i] = cyc;
      end
    end
  end

  logic       chk_on = 1'b0;
  logic [1:0] eph;
  logic [7:0] ea, ed;
  logic       ew;
  always @(negedge clk) begin
    if (chk_on) begin
      eph = exp_phase();
      ea = 8'd0; ed = 8'd0; ew = 1'b0;
      case (eph)
        2'd1: begin
          ea = bus.init_addr; ed = bus.init_wrdata;
          ew = bus.init_wren;
        end
        2'd2: begin
          ea = bus.ksa_addr; ed = bus.ksa_wrdata;
          ew = bus.ksa_wren;
        end
        2'd3: begin
          ea = bus.prga_addr; ed = bus.prga_wrdata;
          ew = bus.prga_wren;
        end
        default: ;
      endcase
      chk("cyc_rdy", 32'(bus.rdy), 32'(model_idle()));
      chk("cyc_phase", 32'(bus.phase), 32'(eph));
      chk("cyc_key_q", 32'(bus.key_q), 32'(exp_key()));
      chk("cyc_init_en", 32'(bus.init_en), 32'(run_on && cyc == c0));
      chk("cyc_ksa_en", 32'(bus.ksa_en), 32'(run_on && cyc == c1));
      chk("cyc_prga_en", 32'(bus.prga_en), 32'(run_on && cyc == c2));
      chk("cyc_s_addr", 32'(bus.s_addr), 32'(ea));
      chk("cyc_s_wrdata", 32'(bus.s_wrdata), 32'(ed));
      chk("cyc_s_wren", 32'(bus.s_wren), 32'(ew));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [23:0] k, input int l0,
                           input int l1, input int l2, input int d0);
    key_prev  = exp_key();
    key_new   = k;
    blen[0]   = l0;
    blen[1]   = l1;
    blen[2]   = l2;
    g0        = cyc + 1;
    c0        = g0 + d0;
    c1        = c0 + 3 + l0;
    c2        = c1 + 3 + l1;
    cend      = c2 + 3 + l2;
    blk_until = cyc + d0;
    run_on    = 1'b1;
    bus.key   = k;
    bus.en    = 1'b1;
    step();
    bus.en    = 1'b0;
  endtask

  task automatic drive_rand(input logic stray);
    bus.init_addr   = 8'($urandom);
    bus.init_wrdata = 8'($urandom);
    bus.init_wren   = 1'($urandom);
    bus.ksa_addr    = 8'($urandom);
    bus.ksa_wrdata  = 8'($urandom);
    bus.ksa_wren    = 1'($urandom);
    bus.prga_addr   = 8'($urandom);
    bus.prga_wrdata = 8'($urandom);
    bus.prga_wren   = 1'($urandom);
    bus.en  = stray && !model_idle() && ($urandom_range(0, 5) == 0);
    bus.key = 24'($urandom);
  endtask

  task automatic wait_idle(input logic rnd);
    while (!model_idle()) begin
      drive_rand(rnd);
      step();
    end
    bus.en = 1'b0;
  endtask

  typedef struct {
    logic [1:0] ph;
    logic [7:0] ia, id; logic iw;
    logic [7:0] ka, kd; logic kw;
    logic [7:0] pa, pd; logic pw;
    logic [7:0] xa, xd; logic xw;
  } vec_t;
  vec_t tbl[7];

  int base[3];

  initial begin
    tbl[0] = '{2'd1, 8'h11, 8'h22, 1'b1, 8'h5A, 8'hC3, 1'b1,
               8'h77, 8'h88, 1'b1, 8'h11, 8'h22, 1'b1};
    tbl[1] = '{2'd1, 8'h00, 8'hFF, 1'b0, 8'h12, 8'h34, 1'b1,
               8'h56, 8'h78, 1'b1, 8'h00, 8'hFF, 1'b0};
    tbl[2] = '{2'd2, 8'h33, 8'h44, 1'b1, 8'h5A, 8'h00, 1'b0,
               8'h66, 8'h55, 1'b1, 8'h5A, 8'h00, 1'b0};
    tbl[3] = '{2'd2, 8'h33, 8'h44, 1'b1, 8'h5A, 8'hC3, 1'b1,
               8'h66, 8'h55, 1'b1, 8'h5A, 8'hC3, 1'b1};
    tbl[4] = '{2'd3, 8'hA1, 8'hA2, 1'b1, 8'hB1, 8'hB2, 1'b1,
               8'hFE, 8'h01, 1'b1, 8'hFE, 8'h01, 1'b1};
    tbl[5] = '{2'd3, 8'hA1, 8'hA2, 1'b1, 8'hB1, 8'hB2, 1'b1,
               8'h09, 8'h08, 1'b0, 8'h09, 8'h08, 1'b0};
    tbl[6] = '{2'd0, 8'hC1, 8'hC2, 1'b1, 8'hD1, 8'hD2, 1'b1,
               8'hE1, 8'hE2, 1'b1, 8'h00, 8'h00, 1'b0};

    bus.en = 1'b0; bus.key = 24'd0;
    bus.init_addr = 8'd0; bus.init_wrdata = 8'd0; bus.init_wren = 1'b1;
    bus.ksa_addr  = 8'd0; bus.ksa_wrdata  = 8'd0; bus.ksa_wren  = 1'b1;
    bus.prga_addr = 8'd0; bus.prga_wrdata = 8'd0; bus.prga_wren = 1'b1;
    blen[0] = 1; blen[1] = 1; blen[2] = 1;

    // Reset held for two edges, then released.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_rdy", 32'(bus.rdy), 32'd1);
      chk("rst_phase", 32'(bus.phase), 32'd0);
      chk("rst_s_wren", 32'(bus.s_wren), 32'd0);
      chk("rst_ens", 32'(eng_en), 32'd0);
      chk("rst_key_q", 32'(bus.key_q), 32'd0);
    end
    rst = 1'b0;
    chk_on = 1'b1;
    step();
    chk("post_rst_rdy", 32'(bus.rdy), 32'd1);

    // Directed long run; arbitration vectors applied in each phase.
    for (int i = 0; i < 3; i++) base[i] = n_en[i];
    start_run(24'h000018, LONG, LONG, LONG, 0);
    for (int i = 0; i < 7; i++) begin
      for (int b = 0; b < 5000 && exp_phase() != tbl[i].ph; b++) step();
      bus.init_addr = tbl[i].ia; bus.init_wrdata = tbl[i].id;
      bus.init_wren = tbl[i].iw;
      bus.ksa_addr  = tbl[i].ka; bus.ksa_wrdata  = tbl[i].kd;
      bus.ksa_wren  = tbl[i].kw;
      bus.prga_addr = tbl[i].pa; bus.prga_wrdata = tbl[i].pd;
      bus.prga_wren = tbl[i].pw;
      @(negedge clk);
      chk("tbl_phase", 32'(bus.phase), 32'(tbl[i].ph));
      chk("tbl_s_addr", 32'(bus.s_addr), 32'(tbl[i].xa));
      chk("tbl_s_wrdata", 32'(bus.s_wrdata), 32'(tbl[i].xd));
      chk("tbl_s_wren", 32'(bus.s_wren), 32'(tbl[i].xw));
      step();
    end
    wait_idle(1'b0);
    @(negedge clk);
    chk("run_init_cnt", 32'(n_en[0] - base[0]), 32'd1);
    chk("run_ksa_cnt", 32'(n_en[1] - base[1]), 32'd1);
    chk("run_prga_cnt", 32'(n_en[2] - base[2]), 32'd1);
    chk("run_init_t", 32'(t_en[0]), 32'(c0));
    chk("run_ksa_t", 32'(t_en[1]), 32'(c1));
    chk("run_prga_t", 32'(t_en[2]), 32'(c2));
    chk("run_key_q", 32'(bus.key_q), 32'h000018);
    chk("run_end_rdy", 32'(bus.rdy), 32'd1);
    chk("run_end_phase", 32'(bus.phase), 32'd0);
    step();

    // init_rdy low for 5 cycles in INIT_GO; stray en mid-run.
    base[0] = n_en[0];
    start_run(24'h123456, 10, 10, 10, 5);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    chk("blk_no_init_en", 32'(n_en[0] - base[0]), 32'd0);
    step();
    bus.en = 1'b1; bus.key = 24'hFFFFFF;
    step();
    bus.en = 1'b0;
    @(negedge clk);
    chk("blk_key_hold", 32'(bus.key_q), 32'h123456);
    wait_idle(1'b0);
    @(negedge clk);
    chk("blk_init_t", 32'(t_en[0]), 32'(c0));
    chk("blk_init_cnt", 32'(n_en[0] - base[0]), 32'd1);
    chk("blk_key_end", 32'(bus.key_q), 32'h123456);
    step();

    // Reset during KSA_WAIT, then a fresh run from init.
    start_run(24'hABCDEF, 5, 50, 5, 0);
    while (cyc < c1 + 3) step();
    bus.ksa_wren = 1'b1;
    rst = 1'b1;
    step();
    rst = 1'b0; run_on = 1'b0; key_prev = 24'd0;
    @(negedge clk);
    chk("mid_rst_phase", 32'(bus.phase), 32'd0);
    chk("mid_rst_s_wren", 32'(bus.s_wren), 32'd0);
    chk("mid_rst_rdy", 32'(bus.rdy), 32'd1);
    chk("mid_rst_ksa_en", 32'(bus.ksa_en), 32'd0);
    step();
    start_run(24'h0F0F0F, 3, 3, 3, 0);
    wait_idle(1'b1);
    @(negedge clk);
    chk("restart_init_t", 32'(t_en[0]), 32'(c0));
    chk("restart_key", 32'(bus.key_q), 32'h0F0F0F);

    // Random runs, some back-to-back, stray en while busy.
    for (int r = 0; r < 25; r++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        drive_rand(1'b0);
        step();
      end
      start_run(24'($urandom), $urandom_range(1, 30),
                $urandom_range(1, 30), $urandom_range(1, 30),
                $urandom_range(0, 3));
      wait_idle(1'b1);
      chk("rnd_init_t", 32'(t_en[0]), 32'(c0));
      chk("rnd_ksa_t", 32'(t_en[1]), 32'(c1));
      chk("rnd_prga_t", 32'(t_en[2]), 32'(c2));
    end
    step();

`ifdef ARC4_CTRL_WDOG_EN
    // ksa never finishes: ERR after TO wait cycles, cleared by rst.
    chk_on = 1'b0;
    start_run(24'h555555, 4, 100000, 4, 0);
    while (cyc < c1 + TO) begin
      bus.ksa_wren = 1'b1;
      step();
    end
    @(negedge clk);
    chk("wd_pre_err", 32'(bus.err), 32'd0);
    chk("wd_pre_phase", 32'(bus.phase), 32'd2);
    step();
    @(negedge clk);
    chk("wd_err", 32'(bus.err), 32'd1);
    chk("wd_rdy", 32'(bus.rdy), 32'd0);
    chk("wd_phase", 32'(bus.phase), 32'd2);
    chk("wd_s_wren", 32'(bus.s_wren), 32'd0);
    chk("wd_s_addr", 32'(bus.s_addr), 32'd0);
    for (int i = 0; i < 10; i++) step();
    bus.en = 1'b1;
    step();
    bus.en = 1'b0;
    @(negedge clk);
    chk("wd_err_hold", 32'(bus.err), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0; run_on = 1'b0; key_prev = 24'd0;
    @(negedge clk);
    chk("wd_rst_err", 32'(bus.err), 32'd0);
    chk("wd_rst_rdy", 32'(bus.rdy), 32'd1);
    chk_on = 1'b1;
    step();
`endif

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1);
  end

endmodule

// File: doc/arc4_ctrl.md
# arc4_ctrl

Top-level sequencer for the ARC4 decrypt datapath. Runs the three sub-engines in order (S-array init, key-scheduling, pseudo-random generation/decrypt) using the en/rdy handshake, and arbitrates the single-port S memory between them. Sits between the task top (switch key, start button) and the `init`/`ksa`/`prga` instances. An optional watchdog flags a hung sub-engine.

## Interface

Parameters:
- `TIMEOUT_CYCLES`, default 8192: watchdog limit per phase. Only used when the watchdog is compiled in.

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  start request, sampled only while `rdy`=1
- `rdy`  out  1  controller idle and able to accept `en`
- `key`  in  24  ARC4 key, captured when `en` is accepted
- `key_q`  out  24  latched key, fed to `ksa` and `prga`
- `init_en`  out  1  one-cycle start pulse to `init`
- `init_rdy`  in  1  `init` idle
- `init_addr`, `init_wrdata`  in  8 each  `init` S-port address and write data
- `init_wren`  in  1  `init` S-port write enable
- `ksa_en`, `ksa_rdy`, `ksa_addr`, `ksa_wrdata`, `ksa_wren`: same roles as the `init_*` ports, for `ksa`
- `prga_en`, `prga_rdy`, `prga_addr`, `prga_wrdata`, `prga_wren`: same roles as the `init_*` ports, for `prga`
- `s_addr`  out  8  S memory address
- `s_wrdata`  out  8  S memory write data
- `s_wren`  out  1  S memory write enable
- `phase`  out  2  0 idle, 1 init, 2 ksa, 3 prga
- `err`  out  1  watchdog tripped. Present only with `ARC4_CTRL_WDOG_EN`.

## Operation

States: IDLE, INIT_GO, INIT_WAIT, KSA_GO, KSA_WAIT, PRGA_GO, PRGA_WAIT. With the watchdog compiled in there is also ERR.

- **Reset:** state=IDLE, `key_q`=0, `phase`=0, `err`=0. All `*_en`=0, `s_wren`=0, `s_addr`=0, `s_wrdata`=0. `rdy`=1 from the first clock edge with `rst` high.
- **IDLE:** `rdy`=1. `en`=1 latches `key` into `key_q` and moves to INIT_GO.
- **X_GO (X = init/ksa/prga):**
  - Drive `X_en = X_rdy` combinationally.
  - When `X_rdy`=1, go to X_WAIT. This makes `X_en` exactly a one-cycle pulse.
  - When `X_rdy`=0, hold in X_GO with `X_en`=0.
- **X_WAIT:**
  - The first cycle is a guard cycle; `X_rdy` is ignored because the sub-engine drops `rdy` one cycle after `en`.
  - From the second cycle on, `X_rdy`=1 advances the FSM: INIT_WAIT→KSA_GO, KSA_WAIT→PRGA_GO, PRGA_WAIT→IDLE.
- **`en` while `rdy`=0:** ignored, with no queueing. `key` changes after capture have no effect until the next accepted `en`.
- **S-port arbitration (combinational from the state register):**
  - INIT_* states pass the `init_*` port through.
  - KSA_* states pass the `ksa_*` port through.
  - PRGA_* states pass the `prga_*` port through.
  - IDLE and ERR drive `s_wren`=0, `s_addr`=0, `s_wrdata`=0.
  - Writes from a non-owning engine never reach memory.
- **`phase`:** follows the state group (1/2/3). It is 0 in IDLE and holds its last value in ERR.
- **Reset mid-operation:** returns to IDLE on the next edge. Any `*_en` and `s_wren` asserted that cycle are low after the edge. The sub-engines share `rst`.

## Timing

- Accept to `init_en`: `en` is sampled in IDLE at edge N. INIT_GO holds from N. `init_en` is high during cycle N+1 if `init_rdy`=1.
- Phase handoff costs 1 cycle (X_WAIT→Y_GO) plus the Y_GO cycle in which `Y_en` pulses. Total controller overhead is 2 cycles per phase boundary.
- PRGA completion: `rdy` rises one cycle after `prga_rdy` is seen high in PRGA_WAIT (post-guard).
- The S-port mux adds 0 cycles. The sub-engine's own memory-latency assumptions are unchanged.
- Back-to-back runs: `en` in the first IDLE cycle after completion is accepted.

## Configuration

- `ARC4_CTRL_WDOG_EN` defined:
  - A 16-bit counter clears on every state change and increments in each X_WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES`, the FSM goes to ERR with `err`=1, `rdy`=0 and the S port idle.
  - ERR exits only on `rst`.
- `ARC4_CTRL_WDOG_EN` undefined:
  - There is no counter, no ERR state and no `err` port.
  - X_WAIT waits indefinitely.

## Test plan

- Reset with `rst`=1 for 2 cycles → `rdy`=1, `phase`=0, `s_wren`=0 and every `*_en`=0 while in reset and after release.
- `key`=24'h000018 with a 1-cycle `en` pulse; stub engines each take 300 cycles → `init_en`, `ksa_en`, `prga_en` each pulse exactly once, in that order; `key_q`=24'h000018; `rdy` returns to 1 and `phase`=0 at the end.
- Arbitration: during KSA, drive `init_wren`=1 and `prga_wren`=1 with `ksa_addr`=8'h5A, `ksa_wren`=0 → `s_wren`=0 and `s_addr`=8'h5A. Then set `ksa_wren`=1, `ksa_wrdata`=8'hC3 → `s_wren`=1, `s_wrdata`=8'hC3.
- Hold `init_rdy`=0 for 5 cycles on entering INIT_GO → `init_en` stays low, then pulses once in the cycle `init_rdy` rises. An `en` pulse mid-run with `key`=24'hFFFFFF leaves `key_q` unchanged.
- Assert `rst` in KSA_WAIT → IDLE after 1 edge: `phase`=0, `s_wren`=0. A new `en` restarts from init.
- With `ARC4_CTRL_WDOG_EN` and `TIMEOUT_CYCLES`=64, hold `ksa_rdy` low forever → `err`=1 after 64 KSA_WAIT cycles, `rdy`=0, `phase`=2. `rst` clears `err`.
